// File: rtl/ulbf_data_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ulbf_data_pkg
// Description : Shared types and widths for the ulbf data master sequencer.
//               Holds the sequencer state encoding and the counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ulbf_data_pkg;

  localparam int ADDR_W = 16;  // BRAM word address / rollover width
  localparam int CNT_W  = 12;  // block_size and niter width
  localparam int BEAT_W = 28;  // total beats per run (CNT_W + ADDR_W)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ulbf_data_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : ulbf_data_sfifo
// Description : Small synchronous FIFO with occupancy count. The head entry
//               is presented combinationally and forced to zero while empty.
// Ports       : clk, rst_n (async, active-low), clr (sync flush),
//               wr_en/wr_data, rd_en/rd_data, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module ulbf_data_sfifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is only legal when the head leaves this cycle.
  assign do_wr   = wr_en && ((count != FULL) || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ulbf_data_mstr_seq.sv
`default_nettype none
// ============================================================================
// Module      : ulbf_data_mstr_seq
// Description : Data master sequencer. Reads BRAM words 0..rollover_addr-1,
//               niter times, and streams them on AXI4-Stream with tlast every
//               block_size beats and on the final beat of the run.
// Ports       : m_axis_clk, m_axis_aresetn (async, active-low),
//               m_axis_rst (sync soft reset), go, block_size, niter,
//               rollover_addr  -- CSR controls
//               bram_addr, bram_en, bram_dout -- BRAM port B
//               m_axis_tdata/tvalid/tlast/tready -- output stream
//               m_done, addrb_wire -- CSR status
// Revision    : 1.0 - initial release
// ============================================================================
module ulbf_data_mstr_seq
  import ulbf_data_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_aresetn,
  input  logic              m_axis_rst,
  input  logic              go,
  input  logic [CNT_W-1:0]  block_size,
  input  logic [CNT_W-1:0]  niter,
  input  logic [ADDR_W-1:0] rollover_addr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              m_done,
  output logic [ADDR_W-1:0] addrb_wire
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic              go_d;
  logic [CNT_W-1:0]  bs_s;
  logic [CNT_W-1:0]  niter_s;
  logic [ADDR_W-1:0] roll_s;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  pass;
  logic [RD_LAT:1]   vld;       // vld[k]: read issued k cycles ago
  logic [CNT_W-1:0]  blk_cnt;   // position inside the current packet
  logic [BEAT_W-1:0] beat_cnt;  // beats written so far this run
  logic [BEAT_W-1:0] total;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_wr;
  logic              tlast_w;
  logic              pop;
  logic              can_issue;
  logic              last_issue;
  logic              wrap;
  int                inflight;
  int                occ;

  // tlast is decided on the write side: beats leave the FIFO in issue order,
  // so storing it with the data keeps the output path free of counters.
  assign total      = BEAT_W'(niter_s) * BEAT_W'(roll_s);
  assign fifo_wr    = vld[RD_LAT];
  assign tlast_w    = (blk_cnt == bs_s - 1'b1) || (beat_cnt == total - 1'b1);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign wrap       = (addr == roll_s - 1'b1);
  assign last_issue = wrap && (pass == niter_s - 1'b1);

  // Credit check: everything already requested must fit, counting the slot
  // freed by a beat leaving this cycle so a full pipeline sustains 1 beat/cycle.
  always_comb begin
    inflight = int'(bram_en);
    for (int i = 1; i <= RD_LAT; i++) begin
      inflight = inflight + int'(vld[i]);
    end
    occ       = int'(fifo_count) - int'(pop) + inflight + 1;
    can_issue = (occ <= FIFO_DEPTH);
  end

  always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state      <= IDLE;
      go_d       <= 1'b0;
      bs_s       <= '0;
      niter_s    <= '0;
      roll_s     <= '0;
      addr       <= '0;
      pass       <= '0;
      vld        <= '0;
      blk_cnt    <= '0;
      beat_cnt   <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      addrb_wire <= '0;
      m_done     <= 1'b0;
    end else begin
      // go_d keeps following go through a soft reset so a held-high go
      // cannot restart a run on its own.
      go_d <= go;
      if (m_axis_rst) begin
        state      <= IDLE;
        addr       <= '0;
        pass       <= '0;
        vld        <= '0;
        blk_cnt    <= '0;
        beat_cnt   <= '0;
        bram_en    <= 1'b0;
        bram_addr  <= '0;
        addrb_wire <= '0;
        m_done     <= 1'b0;
      end else begin
        addrb_wire <= bram_addr;
        vld[1]     <= bram_en;
        for (int i = 2; i <= RD_LAT; i++) begin
          vld[i] <= vld[i-1];
        end
        if (fifo_wr) begin
          blk_cnt  <= tlast_w ? '0 : blk_cnt + 1'b1;
          beat_cnt <= beat_cnt + 1'b1;
        end
        bram_en <= 1'b0;

        case (state)
          IDLE: begin
            if (go && !go_d) begin
              bs_s     <= block_size;
              niter_s  <= niter;
              roll_s   <= rollover_addr;
              addr     <= '0;
              pass     <= '0;
              blk_cnt  <= '0;
              beat_cnt <= '0;
              if ((block_size == '0) || (niter == '0) || (rollover_addr == '0)) begin
                state  <= DONE;
                m_done <= 1'b1;
              end else begin
                state  <= RUN;
              end
            end
          end
          RUN: begin
            if (can_issue) begin
              bram_en   <= 1'b1;
              bram_addr <= addr;
              if (wrap) begin
                addr <= '0;
                pass <= pass + 1'b1;
              end else begin
                addr <= addr + 1'b1;
              end
              if (last_issue) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (fifo_empty && !bram_en && (vld == '0)) begin
              state  <= DONE;
              m_done <= 1'b1;
            end
          end
          DONE: begin
            if (!go) begin
              state  <= IDLE;
              m_done <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  ulbf_data_sfifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_axis_clk),
    .rst_n   (m_axis_aresetn),
    .clr     (m_axis_rst),
    .wr_en   (fifo_wr),
    .wr_data ({tlast_w, bram_dout}),
    .rd_en   (m_axis_tready),
    .rd_data ({m_axis_tlast, m_axis_tdata}),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ulbf_data_mstr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ulbf_data_mstr_seq
// Description : Self-checking bench for ulbf_data_mstr_seq. Expected beats
//               are pushed to a queue at start of each run and compared as
//               the stream delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ulbf_data_mstr_seq;
  import ulbf_data_pkg::*;

  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              soft_rst;
  logic              go;
  logic [11:0]       block_size;
  logic [11:0]       niter;
  logic [15:0]       rollover_addr;
  logic [15:0]       bram_addr;
  logic              bram_en;
  logic [DATA_W-1:0] bram_dout = '0;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic              m_done;
  logic [15:0]       addrb_wire;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;   // 0 ready, 1 toggle, 2 random stalls
  int beats_seen = 0;
  bit quiet    = 0;   // no read and no beat allowed while set
  logic [DATA_W:0] exp_q [$];
  logic [DATA_W:0] mon_exp;
  logic [DATA_W:0] prev_beat;
  bit prev_stall = 0;

  typedef struct {
    int bs;
    int ni;
    int ro;
    int md;
    int beats;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  ulbf_data_mstr_seq #(
    .DATA_W     (DATA_W),
    .RD_LAT     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .m_axis_clk     (clk),
    .m_axis_aresetn (aresetn),
    .m_axis_rst     (soft_rst),
    .go             (go),
    .block_size     (block_size),
    .niter          (niter),
    .rollover_addr  (rollover_addr),
    .bram_addr      (bram_addr),
    .bram_en        (bram_en),
    .bram_dout      (bram_dout),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tlast   (tlast),
    .m_axis_tready  (tready),
    .m_done         (m_done),
    .addrb_wire     (addrb_wire)
  );

  function automatic logic [DATA_W-1:0] word(input int a);
    return {(DATA_W/16){16'(a)}};
  endfunction

  // BRAM model, read latency 2: address sampled on one edge, data the next.
  logic [15:0] bram_a1 = '0;
  logic        bram_e1 = 1'b0;
  always @(posedge clk) begin
    bram_e1 <= bram_en;
    if (bram_en) bram_a1 <= bram_addr;
    if (bram_e1) bram_dout <= word(int'(bram_a1));
  end

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tready driver
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1:       tready = ~tready;
        2:       tready = 1'($urandom_range(0, 1));
        default: tready = 1'b1;
      endcase
    end
  end

  // Stream monitor / scoreboard
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 0;
    end else begin
      if (quiet) begin
        check_i("quiet_bram_en", int'(bram_en), 0);
        check_i("quiet_tvalid", int'(tvalid), 0);
      end
      check_i("fifo_count_bound", (int'(dut.u_fifo.count) <= 4) ? 1 : 0, 1);
      if (prev_stall) begin
        check_i("stall_tvalid", int'(tvalid), 1);
        check_w("stall_beat", {tlast, tdata}, prev_beat);
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tlast, tdata};
      if (tvalid && tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h while no beat expected", {tlast, tdata});
        end else begin
          mon_exp = exp_q.pop_front();
          check_w("beat", {tlast, tdata}, mon_exp);
        end
      end
      if (m_done) check_i("done_after_last_beat", exp_q.size(), 0);
    end
  end

  task automatic start_run(input int bs, input int ni, input int ro);
    int total;
    int blk;
    bit last;
    @(posedge clk); #1;
    block_size    = 12'(bs);
    niter         = 12'(ni);
    rollover_addr = 16'(ro);
    total = (bs == 0 || ni == 0 || ro == 0) ? 0 : ni * ro;
    blk = 0;
    for (int i = 0; i < total; i++) begin
      last = (blk == bs - 1) || (i == total - 1);
      exp_q.push_back({last, word(i % ro)});
      blk = last ? 0 : blk + 1;
    end
    beats_seen = 0;
    quiet = (total == 0);
    go = 1'b1;
  endtask

  task automatic finish_run(input int beats, input int hold);
    int cyc;
    bit ok;
    int limit;
    cyc = 0;
    ok = 0;
    limit = (beats == 0) ? 3 : 4000;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (m_done) ok = 1;
    end
    check_i("done_reached", int'(ok), 1);
    check_i("beat_count", beats_seen, beats);
    check_i("queue_drained", exp_q.size(), 0);
    if (mode == 0 && beats > 0) check_i("throughput", (cyc <= beats + 12) ? 1 : 0, 1);
    quiet = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_i("done_held", int'(m_done), 1);
    end
    @(posedge clk); #1;
    go = 1'b0;
    repeat (2) @(negedge clk);
    check_i("done_cleared", int'(m_done), 0);
    check_i("state_idle", int'(dut.state), int'(IDLE));
    quiet = 0;
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (beats_seen < n && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check_i("wait_beats", (beats_seen >= n) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4, 2, 6, 0, 12};
    vecs[1] = '{4, 2, 6, 1, 12};
    vecs[2] = '{4, 2, 6, 2, 12};
    vecs[3] = '{5, 3, 4, 2, 12};
    vecs[4] = '{1, 1, 3, 0, 3};
    vecs[5] = '{4, 0, 6, 0, 0};
    vecs[6] = '{0, 2, 6, 0, 0};
    vecs[7] = '{3, 2, 0, 0, 0};
    vecs[8] = '{7, 1, 1, 1, 1};

    aresetn = 1'b0;
    soft_rst = 1'b0;
    go = 1'b0;
    block_size = '0;
    niter = '0;
    rollover_addr = '0;
    repeat (3) @(posedge clk); #1;
    check_i("rst_bram_en", int'(bram_en), 0);
    check_i("rst_tvalid", int'(tvalid), 0);
    check_i("rst_m_done", int'(m_done), 0);
    check_w("rst_tdata", {tlast, tdata}, '0);
    check_i("rst_addr", int'(bram_addr) + int'(addrb_wire), 0);
    aresetn = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_i("rst_state", int'(dut.state), int'(IDLE));

    for (int v = 0; v < 9; v++) begin
      mode = vecs[v].md;
      start_run(vecs[v].bs, vecs[v].ni, vecs[v].ro);
      finish_run(vecs[v].beats, 0);
      mode = 0;
    end

    // block_size edit mid-run is ignored until the next start
    start_run(4, 2, 6);
    repeat (3) @(posedge clk); #1;
    block_size = 12'd8;
    finish_run(12, 0);
    start_run(8, 2, 6);
    finish_run(12, 0);

    // go held high after done: no restart
    start_run(3, 1, 5);
    finish_run(5, 8);

    // soft reset after beat 5
    start_run(4, 2, 6);
    wait_beats(6);
    soft_rst = 1'b1;
    @(posedge clk); #1;
    soft_rst = 1'b0;
    check_i("srst_state", int'(dut.state), int'(IDLE));
    check_i("srst_tvalid", int'(tvalid), 0);
    check_i("srst_m_done", int'(m_done), 0);
    check_i("srst_bram_en", int'(bram_en), 0);
    exp_q.delete();
    quiet = 1;
    repeat (6) @(posedge clk); #1;
    go = 1'b0;
    quiet = 0;
    start_run(4, 2, 6);
    finish_run(12, 0);

    // asynchronous reset between clock edges
    start_run(4, 2, 6);
    wait_beats(3);
    #2;
    aresetn = 1'b0;
    #1;
    check_i("arst_tvalid", int'(tvalid), 0);
    check_w("arst_beat", {tlast, tdata}, '0);
    check_i("arst_bram_en", int'(bram_en), 0);
    check_i("arst_bram_addr", int'(bram_addr), 0);
    check_i("arst_addrb", int'(addrb_wire), 0);
    check_i("arst_m_done", int'(m_done), 0);
    exp_q.delete();
    go = 1'b0;
    @(negedge clk); #2;
    aresetn = 1'b1;
    start_run(4, 2, 6);
    finish_run(12, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
